// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings and the fetch-stage state type.
package proc_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_JMP = 4'b1000;
   localparam logic [3:0] OP_JZ  = 4'b1001;
   localparam logic [3:0] OP_JC  = 4'b1010;
   localparam logic [3:0] OP_HLT = 4'b1100;

   typedef enum logic [2:0] {
      RESET_WAIT,
      REQ,
      DECODE,
      BRANCH,
      ISSUE,
      HALT
   } fetch_state_t;

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load of a branch target or modulo-2^AW increment.
module pc_counter #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          inc,
   input  logic [AW-1:0] target,
   output logic [AW-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
      end else if (load) begin
         pc <= target;
      end else if (inc) begin
         pc <= pc + AW'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: resolves JMP/JZ/JC locally, issues other words to the control unit.
// Optional imem_ack timeout with sticky fetch_err is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
   import proc_pkg::*;
#(
   parameter int AW          = 8,
   parameter int DW          = 16,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [DW-1:0] imem_rdata,
   output logic [DW-1:0] ir_data,
   output logic          ir_valid,
   input  logic          ir_ready,
   input  logic          cy,
   input  logic          zero,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic          fetch_err
);

   fetch_state_t  state, state_nxt;
   logic [DW-1:0] ir;
   logic          halt_pend;
   logic [3:0]    opcode;
   logic          taken;
   logic          ir_load, pc_load, pc_inc;
   logic          timeout;

   assign opcode = ir[DW-1:DW-4];

`ifdef FETCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] wait_cnt;
   logic          err_q;

   assign timeout   = (state == REQ) && !imem_ack && (wait_cnt == TW'(TIMEOUT_CYC - 1));
   assign fetch_err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         wait_cnt <= (state == REQ && !imem_ack) ? wait_cnt + TW'(1) : '0;
         if (timeout) err_q <= 1'b1;
      end
   end
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RESET_WAIT;
         ir        <= '0;
         halt_pend <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ir_load) ir <= imem_rdata;
         if (state == DECODE) halt_pend <= (opcode == OP_HLT);
      end
   end

   // Flags are only meaningful once the control unit is idle, so they are sampled in BRANCH.
   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_JMP:  taken = 1'b1;
         OP_JZ:   taken = zero;
         OP_JC:   taken = cy;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_inc    = 1'b0;
      case (state)
         RESET_WAIT: state_nxt = REQ;
         REQ: begin
            if (imem_ack) begin
               ir_load   = 1'b1;
               state_nxt = DECODE;
            end else if (timeout) begin
               state_nxt = HALT;
            end
         end
         DECODE: state_nxt = is_branch(opcode) ? BRANCH : ISSUE;
         BRANCH: begin
            if (ir_ready) begin
               pc_load   = taken;
               pc_inc    = !taken;
               state_nxt = REQ;
            end
         end
         ISSUE: begin
            if (ir_ready) begin
               if (halt_pend) begin
                  state_nxt = HALT;
               end else begin
                  pc_inc    = 1'b1;
                  state_nxt = REQ;
               end
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = RESET_WAIT;
      endcase
   end

   pc_counter #(.AW(AW)) u_pc (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (pc_load),
      .inc    (pc_inc),
      .target (ir[AW-1:0]),
      .pc     (pc)
   );

   assign imem_req  = (state == REQ);
   assign imem_addr = pc;
   assign ir_valid  = (state == ISSUE);
   assign ir_data   = ir;
   assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: responsive memory model, randomized waits/backpressure.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic [15:0] ir_data;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic        cy, zero;
   logic [7:0]  pc;
   logic        halted;
   logic        fetch_err;

   fetch_unit #(.AW(8), .DW(16), .TIMEOUT_CYC(15)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_data(ir_data),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .cy(cy), .zero(zero),
      .pc(pc), .halted(halted), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [15:0] mem [256];
   logic [7:0]  fetch_q[$];
   logic [15:0] issue_q[$];
   int          stamp_q[$];
   logic [7:0]  exp_fetch[$];
   logic [15:0] exp_issue[$];
   logic [7:0]  exp_pc;

   int unsigned wait_max = 0;
   int          ready_mode = 0;
   int          bp_left = 0;
   bit          force_ack = 0;
   bit          hang_en = 0;
   logic [7:0]  hang_addr = '0;
   int          hang_cnt = 0;
   int          wait_left = -1;
   int          stab_viol = 0;
   int          valid_cycles = 0;
   int          post_halt_viol = 0;
   bit          prev_stall = 0;
   logic [15:0] prev_data = '0;

   always @(posedge clk) cyc++;

   // Memory responder and control-unit stand-in; drives inputs and logs transfers on negedges.
   always @(negedge clk) begin
      imem_ack = 1'b0;
      if (!rst_n) wait_left = -1;
      if (force_ack) begin
         imem_ack   = 1'b1;
         imem_rdata = 16'hC000;
      end else if (rst_n && imem_req) begin
         if (hang_en && imem_addr == hang_addr) begin
            hang_cnt++;
         end else begin
            if (wait_left < 0) wait_left = int'($urandom_range(wait_max, 0));
            if (wait_left == 0) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr];
               fetch_q.push_back(imem_addr);
               wait_left  = -1;
            end else begin
               wait_left--;
            end
         end
      end
      case (ready_mode)
         0:       ir_ready = 1'b1;
         1:       ir_ready = 1'($urandom_range(1, 0));
         default: ir_ready = 1'b0;
      endcase
      if (bp_left > 0 && ir_valid) begin
         ir_ready = 1'b0;
         bp_left--;
      end
      if (ir_valid) valid_cycles++;
      if (prev_stall && (ir_valid !== 1'b1 || ir_data !== prev_data)) stab_viol++;
      prev_stall = rst_n && ir_valid && !ir_ready;
      prev_data  = ir_data;
      if (rst_n && ir_valid && ir_ready) begin
         issue_q.push_back(ir_data);
         stamp_q.push_back(cyc);
      end
      if (halted && (imem_req || ir_valid)) post_halt_viol++;
   end

   // Architectural reference: walks the program from address 0 using the branch rules.
   function automatic bit model_run(input logic c, input logic z, input int max_fetch);
      logic [7:0]  p;
      logic [15:0] w;
      logic [3:0]  op;
      bit          tk;
      exp_fetch.delete();
      exp_issue.delete();
      p = 8'd0;
      for (int n = 0; n < max_fetch; n++) begin
         exp_fetch.push_back(p);
         w  = mem[p];
         op = w[15:12];
         if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
            tk = (op == 4'h8) || (op == 4'h9 && z) || (op == 4'hA && c);
            p  = tk ? w[7:0] : 8'(p + 1);
         end else begin
            exp_issue.push_back(w);
            if (op == 4'hC) begin
               exp_pc = p;
               return 1'b1;
            end
            p = 8'(p + 1);
         end
      end
      return 1'b0;
   endfunction

   task automatic fill_mem(input logic [15:0] w);
      for (int i = 0; i < 256; i++) mem[i] = w;
   endtask

   task automatic run_prog(input logic c, input logic z, input int max_cyc, output bit hung);
      @(negedge clk); #1;
      rst_n = 1'b0;
      cy    = c;
      zero  = z;
      repeat (2) @(negedge clk);
      #1;
      fetch_q.delete(); issue_q.delete(); stamp_q.delete();
      stab_viol = 0; valid_cycles = 0; post_halt_viol = 0;
      rst_n = 1'b1;
      hung  = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk); #1;
         if (halted) begin
            hung = 1'b0;
            break;
         end
      end
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({imem_req, imem_addr, ir_valid, ir_data} !== 26'd0) begin
         errors++;
         $display("FAIL reset_outputs: req=%b addr=%h valid=%b data=%h, required all zero",
                  imem_req, imem_addr, ir_valid, ir_data);
      end
      checks++;
      if ({pc, halted, fetch_err} !== 10'd0) begin
         errors++;
         $display("FAIL reset_state: pc=%h halted=%b err=%b, required 0/0/0", pc, halted, fetch_err);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
         errors++;
         $display("FAIL first_req: req=%b addr=%h, required 1/00", imem_req, imem_addr);
      end
   endtask

   task automatic test_straight_line();
      logic [15:0] exp_w [3];
      logic [15:0] got;
      bit          hung;
      exp_w[0] = 16'h0123; exp_w[1] = 16'h1012; exp_w[2] = 16'hC000;
      fill_mem(16'h0000);
      mem[0] = 16'h0123; mem[1] = 16'h1012; mem[2] = 16'hC000;
      wait_max = 0; ready_mode = 0;
      run_prog(1'b0, 1'b0, 100, hung);
      checks++;
      if (hung || issue_q.size() != 3) begin
         errors++;
         $display("FAIL straight_count: hung=%0d issued=%0d, required 0/3", hung, issue_q.size());
      end
      for (int i = 0; i < 3; i++) begin
         got = (i < issue_q.size()) ? issue_q[i] : 16'hxxxx;
         checks++;
         if (got !== exp_w[i]) begin
            errors++;
            $display("FAIL straight_word%0d: got %h, required %h", i, got, exp_w[i]);
         end
      end
      checks++;
      if (stamp_q.size() != 3 || stamp_q[1] - stamp_q[0] != 3 || stamp_q[2] - stamp_q[1] != 3) begin
         errors++;
         $display("FAIL straight_latency: issue spacing not 3 cycles (%0d issues)", stamp_q.size());
      end
      checks++;
      if (pc !== 8'd2 || halted !== 1'b1 || post_halt_viol != 0) begin
         errors++;
         $display("FAIL straight_halt: pc=%h halted=%b post_halt=%0d, required 02/1/0",
                  pc, halted, post_halt_viol);
      end
   endtask

   task automatic test_backpressure();
      bit hung;
      fill_mem(16'h0000);
      mem[0] = 16'h0123; mem[1] = 16'hC000;
      wait_max = 0; ready_mode = 0; bp_left = 5;
      run_prog(1'b0, 1'b0, 100, hung);
      checks++;
      if (issue_q.size() != 2 || issue_q[0] !== 16'h0123) begin
         errors++;
         $display("FAIL bp_transfer: issued=%0d first=%h, required 2/0123",
                  issue_q.size(), (issue_q.size() > 0) ? issue_q[0] : 16'hxxxx);
      end
      checks++;
      if (stab_viol != 0 || valid_cycles != 7) begin
         errors++;
         $display("FAIL bp_stable: violations=%0d valid_cycles=%0d, required 0/7", stab_viol, valid_cycles);
      end
      checks++;
      if (pc !== 8'd1 || fetch_q.size() != 2) begin
         errors++;
         $display("FAIL bp_pc: pc=%h fetches=%0d, required 01/2", pc, fetch_q.size());
      end
   endtask

   task automatic test_branches();
      logic [15:0] w0 [4];
      logic        cs [4];
      logic        zs [4];
      logic [7:0]  last [4];
      logic [7:0]  got;
      bit          hung, ok;
      w0[0] = 16'h8005; cs[0] = 0; zs[0] = 1; last[0] = 8'h09;
      w0[1] = 16'h8005; cs[1] = 0; zs[1] = 0; last[1] = 8'h06;
      w0[2] = 16'hA003; cs[2] = 1; zs[2] = 0; last[2] = 8'h03;
      w0[3] = 16'hA003; cs[3] = 0; zs[3] = 1; last[3] = 8'h01;
      for (int s = 0; s < 4; s++) begin
         fill_mem(16'hC000);
         mem[0] = w0[s];
         mem[5] = 16'h9009;
         ok = model_run(cs[s], zs[s], 20);
         wait_max = 2; ready_mode = 1;
         run_prog(cs[s], zs[s], 200, hung);
         got = (fetch_q.size() > 0) ? fetch_q[fetch_q.size() - 1] : 8'hxx;
         checks++;
         if (hung || got !== last[s] || pc !== last[s]) begin
            errors++;
            $display("FAIL branch%0d_target: last_fetch=%h pc=%h hung=%0d, required %h", s, got, pc, hung, last[s]);
         end
         checks++;
         if (!ok || fetch_q != exp_fetch || issue_q != exp_issue) begin
            errors++;
            $display("FAIL branch%0d_trace: fetches=%0d/%0d issued=%0d/%0d (got/required)",
                     s, fetch_q.size(), exp_fetch.size(), issue_q.size(), exp_issue.size());
         end
      end
   endtask

   task automatic test_wrap();
      bit         hung;
      logic [7:0] a [3];
      fill_mem(16'hC000);
      mem[0] = 16'h80FF; mem[255] = 16'h0123;
      wait_max = 0; ready_mode = 0;
      run_prog(1'b0, 1'b0, 12, hung);
      for (int i = 0; i < 3; i++) a[i] = (i < fetch_q.size()) ? fetch_q[i] : 8'hxx;
      checks++;
      if (a[0] !== 8'h00 || a[1] !== 8'hFF || a[2] !== 8'h00) begin
         errors++;
         $display("FAIL wrap_addr: fetches %h %h %h, required 00 FF 00", a[0], a[1], a[2]);
      end
      checks++;
      if (issue_q.size() == 0 || issue_q[0] !== 16'h0123 || halted !== 1'b0) begin
         errors++;
         $display("FAIL wrap_issue: issued=%0d halted=%b, required 0123 issued and not halted",
                  issue_q.size(), halted);
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      fill_mem(16'hC000);
      mem[0] = 16'h0123;
      wait_max = 0; ready_mode = 0;
      hang_en = 1; hang_addr = 8'h00;
      @(negedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (imem_req) begin
            found = 1;
            break;
         end
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (!found || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_req: saw_req=%0d req_after_reset=%b, required 1/0", found, imem_req);
      end
      force_ack = 1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (ir_data !== 16'h0000 || ir_valid !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_stray: ir_data=%h valid=%b halted=%b, required 0000/0/0",
                  ir_data, ir_valid, halted);
      end
      fetch_q.delete(); issue_q.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      force_ack = 0; hang_en = 0;
      for (int i = 0; i < 50 && !halted; i++) begin
         @(negedge clk); #1;
      end
      checks++;
      if (fetch_q.size() != 2 || fetch_q[0] !== 8'h00 || issue_q.size() != 2 || issue_q[0] !== 16'h0123) begin
         errors++;
         $display("FAIL rst_mid_resume: fetches=%0d issued=%0d first=%h, required 2/2/0123",
                  fetch_q.size(), issue_q.size(), (issue_q.size() > 0) ? issue_q[0] : 16'hxxxx);
      end
   endtask

   task automatic test_random();
      logic [15:0] w;
      logic [3:0]  op;
      logic        c, z;
      bit          ok, hung;
      int          r;
      for (int t = 0; t < 6; t++) begin
         ok = 0;
         c  = 1'($urandom);
         z  = 1'($urandom);
         for (int tries = 0; tries < 40 && !ok; tries++) begin
            for (int i = 0; i < 256; i++) begin
               r = int'($urandom_range(99, 0));
               if (r < 18) begin
                  w = {4'h8 + 4'($urandom_range(2, 0)), 4'h0, 8'($urandom)};
               end else if (r < 24) begin
                  w = {4'hC, 12'($urandom)};
               end else begin
                  op = 4'($urandom);
                  if (op == 4'h8 || op == 4'h9 || op == 4'hA || op == 4'hC) op = 4'h1;
                  w = {op, 12'($urandom)};
               end
               mem[i] = w;
            end
            ok = model_run(c, z, 80);
         end
         wait_max = 3; ready_mode = 1;
         run_prog(c, z, 3000, hung);
         checks++;
         if (!ok || hung || fetch_q != exp_fetch) begin
            errors++;
            $display("FAIL rand%0d_fetch: hung=%0d fetches=%0d required=%0d", t, hung, fetch_q.size(), exp_fetch.size());
         end
         checks++;
         if (issue_q != exp_issue) begin
            errors++;
            $display("FAIL rand%0d_issue: issued=%0d required=%0d", t, issue_q.size(), exp_issue.size());
         end
         checks++;
         if (pc !== exp_pc || stab_viol != 0 || post_halt_viol != 0 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_end: pc=%h required %h stab=%0d post_halt=%0d err=%b",
                     t, pc, exp_pc, stab_viol, post_halt_viol, fetch_err);
         end
      end
      ready_mode = 0; wait_max = 0;
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      bit hung;
      fill_mem(16'hC000);
      for (int i = 0; i < 4; i++) mem[i] = 16'h0001;
      hang_en = 1; hang_addr = 8'h04; hang_cnt = 0;
      wait_max = 0; ready_mode = 0;
      run_prog(1'b0, 1'b0, 200, hung);
      checks++;
      if (hung || fetch_err !== 1'b1 || halted !== 1'b1) begin
         errors++;
         $display("FAIL timeout_flags: hung=%0d err=%b halted=%b, required 0/1/1", hung, fetch_err, halted);
      end
      checks++;
      if (pc !== 8'h04 || imem_req !== 1'b0 || hang_cnt != 15) begin
         errors++;
         $display("FAIL timeout_state: pc=%h req=%b req_cycles=%0d, required 04/0/15", pc, imem_req, hang_cnt);
      end
      hang_en = 0;
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      cy    = 1'b0;
      zero  = 1'b0;
      fill_mem(16'hC000);
      test_reset();
      test_straight_line();
      test_backpressure();
      test_branches();
      test_wrap();
      test_reset_mid();
      test_random();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
